// File: rtl/control_unit_types_pkg.sv
// Control-unit types: hazard sequencer state encoding.
package control_unit_types_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } hz_state_t;

endpackage

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: register index and machine word.
package cpu_types_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    localparam word_t WORD_MAX = '1;

endpackage

// File: rtl/pipeline_hazard_ctrl_perf_counter.sv
// Saturating 32-bit event counter for the hazard controller's perf outputs.
// Built only when HAZARD_PERF_EN is defined.
`ifdef HAZARD_PERF_EN
module hazard_perf_counter
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        nRST,
    input  logic        inc,
    output logic [31:0] cnt
);

    word_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != WORD_MAX)) begin
            cnt_d = cnt_q + WORD_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`endif

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register sequencer: per-stage enables/flushes from cache hits, load-use, redirects and halt.
// Define HAZARD_PERF_EN to add the stall_cnt / flush_cnt performance counters.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
    import control_unit_types_pkg::*;
#(
    parameter int unsigned REGW = 5
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dREN,
    input  logic            mem_dWEN,
    input  logic            mem_halt,
    input  logic            ex_dREN,
    input  logic            ex_RegWEN,
    input  logic [REGW-1:0] ex_rt,
    input  logic [REGW-1:0] id_rs,
    input  logic [REGW-1:0] id_rt,
    input  logic            br_taken,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            dmem_mask,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     stall_cnt,
    output logic [31:0]     flush_cnt,
`endif
    output logic            halt
);

    hz_state_t state_q, state_d;
    logic      dmem_done_q, dmem_done_d;
    logic      halt_q, halt_d;

    logic mem_acc_c, mem_ok_c, advance_c, load_use_c, run_c;

    // Hazard terms; advance only exists while running and out of reset
    always_comb begin
        run_c      = nRST && (state_q == RUN);
        mem_acc_c  = mem_dREN | mem_dWEN;
        mem_ok_c   = ~mem_acc_c | dhit | dmem_done_q;
        advance_c  = run_c & ihit & mem_ok_c;
        load_use_c = ex_dREN & ex_RegWEN & (ex_rt != '0)
                   & ((ex_rt == id_rs) | (ex_rt == id_rt));
    end

    always_comb begin
        state_d     = state_q;
        dmem_done_d = dmem_done_q;
        halt_d      = halt_q;
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        dmem_mask   = 1'b0;

        case (state_q)
            RUN: begin
                dmem_mask = dmem_done_q;
                if (advance_c) begin
                    dmem_done_d = 1'b0;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    idex_en     = 1'b1;
                    // Redirect squashes the younger instructions, so a load-use bubble is moot
                    if (br_taken) begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        exmem_flush = 1'b1;
                    end else if (load_use_c) begin
                        idex_flush  = 1'b1;
                    end else begin
                        pc_en       = 1'b1;
                        ifid_en     = 1'b1;
                    end
                    if (mem_halt) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end
                end else if (mem_acc_c && dhit && !ihit) begin
                    dmem_done_d = 1'b1;
                end
            end
            HALTED: begin
                dmem_done_d = 1'b0;
                halt_d      = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        if (!nRST) begin
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_en    = 1'b0;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            exmem_flush = 1'b0;
            dmem_mask   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= RUN;
            dmem_done_q <= 1'b0;
            halt_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dmem_done_q <= dmem_done_d;
            halt_q      <= halt_d;
        end
    end

    assign halt = halt_q;

`ifdef HAZARD_PERF_EN
    logic stall_inc_c, flush_inc_c;

    // A load-use bubble counts as a stall even though the back end advances
    always_comb begin
        stall_inc_c = run_c & (~advance_c | (load_use_c & ~br_taken));
        flush_inc_c = advance_c & br_taken;
    end

    hazard_perf_counter u_stall_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (stall_inc_c),
        .cnt  (stall_cnt)
    );

    hazard_perf_counter u_flush_cnt (
        .CLK  (CLK),
        .nRST (nRST),
        .inc  (flush_inc_c),
        .cnt  (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl; expected output vectors queued at drive time.
module tb_pipeline_hazard_ctrl;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt;
    logic       ex_dREN, ex_RegWEN, br_taken;
    logic [4:0] ex_rt, id_rs, id_rt;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush, dmem_mask, halt;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    always #5 CLK = ~CLK;

    pipeline_hazard_ctrl #(.REGW(5)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_dREN    (mem_dREN),
        .mem_dWEN    (mem_dWEN),
        .mem_halt    (mem_halt),
        .ex_dREN     (ex_dREN),
        .ex_RegWEN   (ex_RegWEN),
        .ex_rt       (ex_rt),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .br_taken    (br_taken),
        .pc_en       (pc_en),
        .ifid_en     (ifid_en),
        .idex_en     (idex_en),
        .exmem_en    (exmem_en),
        .memwb_en    (memwb_en),
        .ifid_flush  (ifid_flush),
        .idex_flush  (idex_flush),
        .exmem_flush (exmem_flush),
        .dmem_mask   (dmem_mask),
`ifdef HAZARD_PERF_EN
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt),
`endif
        .halt        (halt)
    );

    // {pc,ifid,idex,exmem,memwb en | ifid,idex,exmem flush | dmem_mask | halt}
    localparam logic [9:0] E_HOLD   = 10'b00000_000_0_0;
    localparam logic [9:0] E_MASK   = 10'b00000_000_1_0;
    localparam logic [9:0] E_RUN    = 10'b11111_000_0_0;
    localparam logic [9:0] E_RUNMSK = 10'b11111_000_1_0;
    localparam logic [9:0] E_LU     = 10'b00111_010_0_0;
    localparam logic [9:0] E_BR     = 10'b11111_111_0_0;
    localparam logic [9:0] E_HALTED = 10'b00000_000_0_1;

    // ctl = {ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_RegWEN}
    typedef struct {
        logic [6:0] ctl;
        logic [4:0] exrt, rs, rt;
        logic       br;
        logic [9:0] exp;
    } stim_t;

    logic [9:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic stim_t s(input logic [6:0] ctl, input logic [4:0] exrt, rs, rt,
                                input logic br, input logic [9:0] exp);
        stim_t r;
        r.ctl = ctl; r.exrt = exrt; r.rs = rs; r.rt = rt; r.br = br; r.exp = exp;
        return r;
    endfunction

    function automatic logic [9:0] obs();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, dmem_mask, halt};
    endfunction

    task automatic drive(input stim_t t);
        {ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_RegWEN} = t.ctl;
        ex_rt    = t.exrt;
        id_rs    = t.rs;
        id_rt    = t.rt;
        br_taken = t.br;
        exp_q.push_back(t.exp);
    endtask

    task automatic pulse_reset();
        nRST = 1'b0;
        @(posedge CLK); #1;
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] e, a;
        stim_t t;
        nRST = 1'b0;
        drive(s(7'b1000000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        @(negedge CLK);
        e = exp_q.pop_front(); a = obs(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL reset_held: got %b want %b", a, e); end
        @(posedge CLK); #1;
        nRST = 1'b1;
        t = s(7'b1000000, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN);
        drive(t);
        @(negedge CLK);
        e = exp_q.pop_front(); a = obs(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL reset_first_run: got %b want %b", a, e); end
        @(posedge CLK); #1;
    endtask

    task automatic test_icache_miss();
        stim_t tb[$];
        logic [9:0] e, a;
        tb.push_back(s(7'b0110000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b0110000, 5'd0, 5'd0, 5'd0, 1'b0, E_MASK));
        tb.push_back(s(7'b1010000, 5'd0, 5'd0, 5'd0, 1'b0, E_RUNMSK));
        tb.push_back(s(7'b0010000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b1110000, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN));
        foreach (tb[i]) begin
            drive(tb[i]);
            @(negedge CLK);
            e = exp_q.pop_front(); a = obs(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL icache_miss[%0d]: got %b want %b", i, a, e); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_load_use();
        stim_t tb[$];
        logic [9:0] e, a;
        tb.push_back(s(7'b1000011, 5'd5, 5'd5, 5'd0, 1'b0, E_LU));
        tb.push_back(s(7'b1000001, 5'd5, 5'd5, 5'd0, 1'b0, E_RUN));
        tb.push_back(s(7'b1000011, 5'd7, 5'd1, 5'd7, 1'b0, E_LU));
        tb.push_back(s(7'b1000011, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN));
        tb.push_back(s(7'b1000010, 5'd5, 5'd5, 5'd5, 1'b0, E_RUN));
        tb.push_back(s(7'b0000011, 5'd5, 5'd5, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b1000011, 5'd9, 5'd9, 5'd9, 1'b1, E_BR));
        tb.push_back(s(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b1, E_HOLD));
        tb.push_back(s(7'b1001000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b1101000, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN));
        foreach (tb[i]) begin
            drive(tb[i]);
            @(negedge CLK);
            e = exp_q.pop_front(); a = obs(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL load_use_branch[%0d]: got %b want %b", i, a, e); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_reset_mid_stall();
        stim_t tb[$];
        logic [9:0] e, a;
        tb.push_back(s(7'b0110000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b0010000, 5'd0, 5'd0, 5'd0, 1'b0, E_MASK));
        tb.push_back(s(7'b0010000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b1110000, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN));
        foreach (tb[i]) begin
            if (i == 2) pulse_reset();
            drive(tb[i]);
            @(negedge CLK);
            e = exp_q.pop_front(); a = obs(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL reset_mid_stall[%0d]: got %b want %b", i, a, e); end
            @(posedge CLK); #1;
        end
    endtask

    task automatic test_halt();
        stim_t tb[$];
        logic [9:0] e, a;
        tb.push_back(s(7'b0000100, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b1000100, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN));
        for (int k = 0; k < 10; k++) begin
            tb.push_back(s(7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                           1'($urandom), E_HALTED));
        end
        foreach (tb[i]) begin
            drive(tb[i]);
            @(negedge CLK);
            e = exp_q.pop_front(); a = obs(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL halt[%0d]: got %b want %b", i, a, e); end
            @(posedge CLK); #1;
        end
        nRST = 1'b0;
        drive(s(7'b1000000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        @(negedge CLK);
        e = exp_q.pop_front(); a = obs(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL halt_reset_held: got %b want %b", a, e); end
        @(posedge CLK); #1;
        nRST = 1'b1;
        drive(s(7'b1000000, 5'd0, 5'd0, 5'd0, 1'b0, E_RUN));
        @(negedge CLK);
        e = exp_q.pop_front(); a = obs(); n_cmp++;
        if (a !== e) begin n_bad++; $display("FAIL halt_cleared: got %b want %b", a, e); end
        @(posedge CLK); #1;
    endtask

`ifdef HAZARD_PERF_EN
    task automatic test_perf();
        stim_t tb[$];
        logic [9:0] e, a;
        pulse_reset();
        tb.push_back(s(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b0000000, 5'd0, 5'd0, 5'd0, 1'b0, E_HOLD));
        tb.push_back(s(7'b1000000, 5'd0, 5'd0, 5'd0, 1'b1, E_BR));
        foreach (tb[i]) begin
            drive(tb[i]);
            @(negedge CLK);
            e = exp_q.pop_front(); a = obs(); n_cmp++;
            if (a !== e) begin n_bad++; $display("FAIL perf_stim[%0d]: got %b want %b", i, a, e); end
            @(posedge CLK); #1;
        end
        n_cmp++;
        if (stall_cnt !== 32'd3) begin n_bad++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
        n_cmp++;
        if (flush_cnt !== 32'd1) begin n_bad++; $display("FAIL flush_cnt: got %0d want 1", flush_cnt); end
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFD;
        #1;
        release dut.u_stall_cnt.cnt_q;
        ihit = 1'b0; br_taken = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        n_cmp++;
        if (stall_cnt !== 32'hFFFF_FFFF) begin
            n_bad++; $display("FAIL stall_cnt_sat: got %h want ffffffff", stall_cnt);
        end
    endtask
`endif

    initial begin
        nRST = 1'b0;
        {ihit, dhit, mem_dREN, mem_dWEN, mem_halt, ex_dREN, ex_RegWEN, br_taken} = '0;
        ex_rt = '0; id_rs = '0; id_rt = '0;
        @(posedge CLK); #1;
        test_reset();
        test_icache_miss();
        test_load_use();
        test_reset_mid_stall();
        test_halt();
`ifdef HAZARD_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
